// File: rtl/cache_pkg.sv
// Shared parameters and line layout for the read-only fully associative cache.
// One line is {valid, tag[11:0], word3, word2, word1, word0}.
package cache_pkg;

    localparam int NUM_LINES      = 256;
    localparam int ADDR_W         = 16;
    localparam int TAG_W          = 12;
    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = 141;
    localparam int VALID_BIT      = 140;
    localparam int TAG_HI         = 139;
    localparam int TAG_LO         = 128;
    localparam int IDX_W          = 8;
    localparam int CNT_W          = 32;

    typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/cache_match_encoder.sv
// Collapses the per-entry match vector into a hit flag and the index of the
// lowest-numbered matching entry.
module cache_match_encoder
    import cache_pkg::*;
(
    input  logic [NUM_LINES-1:0] i_match,
    output logic                 o_any_hit,
    output logic [IDX_W-1:0]     o_hit_idx
);

    // Scan downward so the last assignment made is the lowest matching index.
    always_comb begin
        o_hit_idx = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (i_match[i]) begin
                o_hit_idx = IDX_W'(i);
            end
        end
        o_any_hit = |i_match;
    end

endmodule

// File: rtl/fully_associative_cache.sv
// Read-only 256-entry fully associative lookup with zero-cycle latency.
// Contents of `cache` are preloaded externally and survive reset.
module fully_associative_cache
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              hit_out,
    output logic [WORD_W-1:0] data_out
);

    line_t cache [NUM_LINES];

    logic [CNT_W-1:0] access_count;
    logic [CNT_W-1:0] hit_count;

    logic [NUM_LINES-1:0] w_match;
    logic                 w_any_hit;
    logic [IDX_W-1:0]     w_hit_idx;
    line_t                w_hit_line;
    logic [WORD_W-1:0]    w_word;
    logic [TAG_W-1:0]     w_tag;
    logic [1:0]           w_word_sel;
    logic                 w_unused_byte_sel;

    assign w_tag             = addr_in[ADDR_W-1:4];
    assign w_word_sel        = addr_in[3:2];
    assign w_unused_byte_sel = ^addr_in[1:0];

    // Case-equality on the valid bit keeps X/uninitialised entries from hitting.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            w_match[i] = (cache[i][VALID_BIT] === 1'b1) &&
                         (cache[i][TAG_HI:TAG_LO] == w_tag);
        end
    end

    cache_match_encoder u_encoder (
        .i_match   (w_match),
        .o_any_hit (w_any_hit),
        .o_hit_idx (w_hit_idx)
    );

    assign w_hit_line = cache[w_hit_idx];
    assign w_word     = w_hit_line[{w_word_sel, 5'b00000} +: WORD_W];
    assign hit_out    = w_any_hit;
    assign data_out   = w_any_hit ? w_word : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            access_count <= '0;
            hit_count    <= '0;
        end else begin
            access_count <= access_count + CNT_W'(1);
            if (hit_out) begin
                hit_count <= hit_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fully_associative_cache.sv
// Randomised and directed checks of the fully associative cache against a
// table-driven lookup model and cycle-counted statistics.
module tb_fully_associative_cache;
    import cache_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] addr_in;
    logic              hit_out;
    logic [WORD_W-1:0] data_out;

    int n_checks;
    int n_errors;

    logic        m_valid [NUM_LINES];
    logic [11:0] m_tag   [NUM_LINES];
    logic [31:0] m_word  [NUM_LINES][4];

    int exp_hits;

    fully_associative_cache dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr_in  (addr_in),
        .hit_out  (hit_out),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_entry(input int idx, input logic v, input logic [11:0] tag,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        m_valid[idx]   = v;
        m_tag[idx]     = tag;
        m_word[idx][0] = w0;
        m_word[idx][1] = w1;
        m_word[idx][2] = w2;
        m_word[idx][3] = w3;
        dut.cache[idx] = {v, tag, w3, w2, w1, w0};
    endtask

    // First valid entry whose tag equals the address's upper 12 bits.
    task automatic model_lookup(input logic [15:0] a, output logic hit, output logic [31:0] data);
        int sel;
        hit  = 1'b0;
        data = 32'h0;
        sel  = a[3:2];
        for (int i = 0; i < NUM_LINES; i++) begin
            if (!hit && m_valid[i] && m_tag[i] == a[15:4]) begin
                hit  = 1'b1;
                data = m_word[i][sel];
            end
        end
    endtask

    task automatic check_lookup(input string tag, input logic [15:0] a);
        logic        eh;
        logic [31:0] ed;
        model_lookup(a, eh, ed);
        check({tag, "_hit"}, {31'b0, hit_out}, {31'b0, eh});
        check({tag, "_data"}, data_out, ed);
        if (eh) exp_hits++;
    endtask

    initial begin
        logic [15:0] a;
        n_checks = 0;
        n_errors = 0;
        exp_hits = 0;
        rst_n    = 1'b0;
        addr_in  = '0;

        for (int i = 0; i < NUM_LINES; i++) begin
            load_entry(i, 1'b0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0);
        end
        // Random population with tags inside the sweep window.
        for (int i = 20; i < 200; i++) begin
            if ($urandom_range(3, 0) != 0) begin
                load_entry(i, 1'b1, 12'($urandom_range(255, 0)),
                           $urandom, $urandom, $urandom, $urandom);
            end
        end
        load_entry(5,   1'b1, 12'h123, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD);
        load_entry(7,   1'b0, 12'h456, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        load_entry(10,  1'b1, 12'h0FF, 32'h1, 32'h10, 32'h100, 32'h1000);
        load_entry(200, 1'b1, 12'h0FF, 32'h2, 32'h20, 32'h200, 32'h2000);
        load_entry(255, 1'b1, 12'hFFF, 32'h55550000, 32'h55551111, 32'h55552222, 32'h55553333);
        load_entry(0,   1'b1, 12'h000, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D);

        // Directed lookups, held in reset: lookup is live, counters stay 0.
        @(negedge clk);
        check("rst_access", dut.access_count, 32'd0);
        check("rst_hits",   dut.hit_count,    32'd0);
        addr_in = 16'h1238; #1;
        check("valid_hit",  {31'b0, hit_out}, 32'd1);
        check("valid_w2",   data_out, 32'hCCCCCCCC);
        addr_in = 16'h1231; #1;
        check("valid_w0",   data_out, 32'hAAAAAAAA);
        addr_in = 16'h4560; #1;
        check("invalid_hit",  {31'b0, hit_out}, 32'd0);
        check("invalid_data", data_out, 32'h0);
        addr_in = 16'h0FF0; #1;
        check("dup_hit",  {31'b0, hit_out}, 32'd1);
        check("dup_data", data_out, 32'h1);
        addr_in = 16'hFFFC; #1;
        check("top_hit",  {31'b0, hit_out}, 32'd1);
        check("top_data", data_out, 32'h55553333);
        addr_in = 16'h0000; #1;
        check("zero_hit",  {31'b0, hit_out}, 32'd1);
        check("zero_data", data_out, 32'h0A0A0A0A);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_access", dut.access_count, 32'd0);

        // 4096 consecutive addresses starting with reset release.
        exp_hits = 0;
        for (int i = 0; i < 4096; i++) begin
            if (i > 0) @(negedge clk);
            addr_in = 16'(i);
            if (i == 0) rst_n = 1'b1;
            #1;
            check_lookup("sweep", addr_in);
        end
        @(negedge clk);
        check("sweep_access", dut.access_count, 32'd4096);
        check("sweep_hits",   dut.hit_count,    32'(exp_hits));

        // Asynchronous reset mid-stream.
        rst_n = 1'b0; #1;
        check("mid_rst_access", dut.access_count, 32'd0);
        check("mid_rst_hits",   dut.hit_count,    32'd0);
        addr_in = 16'h1238; #1;
        check("mid_rst_hit",  {31'b0, hit_out}, 32'd1);
        check("mid_rst_data", data_out, 32'hCCCCCCCC);
        @(negedge clk);
        check("mid_rst_hold", dut.access_count, 32'd0);

        // Random addresses right after release, no recovery cycle.
        exp_hits = 0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            a = ($urandom_range(1, 0) == 1) ? 16'($urandom_range(4095, 0)) : 16'($urandom);
            addr_in = a;
            if (i == 0) rst_n = 1'b1;
            #1;
            check_lookup("rand", addr_in);
        end
        @(negedge clk);
        check("rand_access", dut.access_count, 32'd64);
        check("rand_hits",   dut.hit_count,    32'(exp_hits));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
